// File: rtl/core101_iss_pkg.sv
// Shared definitions for the issue scheduler slice.
// Holds the unit-select encodings, the FSM state encodings and the default widths.
package core101_iss_pkg;

    localparam int unsigned NUM_UNITS_DEF  = 4;
    localparam int unsigned REG_ADDR_W_DEF = 5;
    localparam int unsigned UOP_W_DEF      = 4;

    // One-hot execution unit selects
    localparam logic [3:0] INT_EXEC_SEL = 4'b0001;
    localparam logic [3:0] BRU_EXEC_SEL = 4'b0010;
    localparam logic [3:0] LSU_EXEC_SEL = 4'b0100;
    localparam logic [3:0] VEC_EXEC_SEL = 4'b1000;

    // Issue buffer FSM states
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_TRAP  = 2'd2;

endpackage : core101_iss_pkg

// File: rtl/issue_scheduler_if.sv
// Decode / issue / writeback bus of the issue scheduler.
// master : decoder, execution units and writeback side (drives *_in, observes *_out)
// slave  : the scheduler itself
interface issue_scheduler_if #(
    parameter int unsigned NUM_UNITS  = 4,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned UOP_W      = 4
);
    logic                  flush_in;
    logic                  dec_valid_in;
    logic                  dec_ready_out;
    logic [NUM_UNITS-1:0]  dec_exec_unit_sel_in;
    logic [UOP_W-1:0]      dec_exec_unit_uop_in;
    logic [REG_ADDR_W-1:0] dec_rs1_in;
    logic [REG_ADDR_W-1:0] dec_rs2_in;
    logic [REG_ADDR_W-1:0] dec_rd_in;
    logic                  dec_rd_write_enable_in;
    logic [NUM_UNITS-1:0]  iss_valid_out;
    logic [NUM_UNITS-1:0]  iss_ready_in;
    logic [UOP_W-1:0]      iss_uop_out;
    logic [REG_ADDR_W-1:0] iss_rd_out;
    logic                  wb_valid_in;
    logic [REG_ADDR_W-1:0] wb_rd_in;
    logic                  iss_exception_out;
    logic                  iss_busy_out;

    modport master (
        output flush_in, dec_valid_in, dec_exec_unit_sel_in, dec_exec_unit_uop_in,
               dec_rs1_in, dec_rs2_in, dec_rd_in, dec_rd_write_enable_in,
               iss_ready_in, wb_valid_in, wb_rd_in,
        input  dec_ready_out, iss_valid_out, iss_uop_out, iss_rd_out,
               iss_exception_out, iss_busy_out
    );

    modport slave (
        input  flush_in, dec_valid_in, dec_exec_unit_sel_in, dec_exec_unit_uop_in,
               dec_rs1_in, dec_rs2_in, dec_rd_in, dec_rd_write_enable_in,
               iss_ready_in, wb_valid_in, wb_rd_in,
        output dec_ready_out, iss_valid_out, iss_uop_out, iss_rd_out,
               iss_exception_out, iss_busy_out
    );

endinterface : issue_scheduler_if

// File: rtl/iss_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register.
// Ports: clk/rst_n; set_en/set_addr marks a register pending, clr_en/clr_addr retires it
// (set wins on a same-register collision); three combinational read ports rd_addr0..2 ->
// pend0..2; any_pend is the OR of all pending bits. Register 0 is never pending.
// Build option ISS_WB_BYPASS_EN: a same-cycle clear is masked out of the read ports.
module iss_scoreboard #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr0,
    input  logic [REG_ADDR_W-1:0] rd_addr1,
    input  logic [REG_ADDR_W-1:0] rd_addr2,
    output logic                  pend0,
    output logic                  pend1,
    output logic                  pend2,
    output logic                  any_pend
);

    localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] view;

    // Decode set/clear requests; x0 is excluded from both
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en && (set_addr != '0)) set_vec[set_addr] = 1'b1;
        if (clr_en && (clr_addr != '0)) clr_vec[clr_addr] = 1'b1;
    end

    // Set is applied after clear so it wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= (pend_q & ~clr_vec) | set_vec;
    end

    // Read view, optionally bypassing the retiring register
    always_comb begin
`ifdef ISS_WB_BYPASS_EN
        view = pend_q & ~clr_vec;
`else
        view = pend_q;
`endif
        view[0] = 1'b0;
    end

    assign pend0    = view[rd_addr0];
    assign pend1    = view[rd_addr1];
    assign pend2    = view[rd_addr2];
    assign any_pend = |pend_q;

endmodule : iss_scoreboard

// File: rtl/issue_scheduler.sv
// Single-entry issue buffer between decode and the INT/BRU/LSU/VEC execution units.
// Holds one instruction, stalls it on RAW/WAW hazards from the scoreboard, dispatches it
// with a one-hot valid/ready handshake, and traps on a non-one-hot unit select.
// Ports: clock_in, reset_n_in (async, active low); bus (issue_scheduler_if.slave) carries
// flush, decode handshake + fields, per-unit issue handshake, writeback, exception, busy.
// Build option ISS_WB_BYPASS_EN: same-cycle writeback clears a hazard (see iss_scoreboard).
module issue_scheduler
    import core101_iss_pkg::*;
#(
    parameter int unsigned NUM_UNITS  = NUM_UNITS_DEF,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned UOP_W      = UOP_W_DEF
) (
    input  logic            clock_in,
    input  logic            reset_n_in,
    issue_scheduler_if.slave bus
);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [NUM_UNITS-1:0]  sel_q;
    logic [UOP_W-1:0]      uop_q;
    logic [REG_ADDR_W-1:0] rs1_q;
    logic [REG_ADDR_W-1:0] rs2_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  we_q;

    logic                  pend_rs1;
    logic                  pend_rs2;
    logic                  pend_rd;
    logic                  any_pend;
    logic                  hazard;
    logic                  sel_onehot;
    logic [NUM_UNITS-1:0]  iss_valid;
    logic                  dispatch;
    logic                  dec_ready;
    logic                  accept;

    iss_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_sb (
        .clk      (clock_in),
        .rst_n    (reset_n_in),
        .set_en   (dispatch & we_q),
        .set_addr (rd_q),
        .clr_en   (bus.wb_valid_in),
        .clr_addr (bus.wb_rd_in),
        .rd_addr0 (rs1_q),
        .rd_addr1 (rs2_q),
        .rd_addr2 (rd_q),
        .pend0    (pend_rs1),
        .pend1    (pend_rs2),
        .pend2    (pend_rd),
        .any_pend (any_pend)
    );

    // Handshake and next-state logic; flush overrides everything
    always_comb begin
        state_d    = state_q;
        iss_valid  = '0;
        dec_ready  = 1'b0;
        hazard     = pend_rs1 | pend_rs2 | (we_q & pend_rd);
        sel_onehot = (bus.dec_exec_unit_sel_in != '0) &&
                     ((bus.dec_exec_unit_sel_in &
                       (bus.dec_exec_unit_sel_in - NUM_UNITS'(1))) == '0);

        if (!bus.flush_in && (state_q == ST_HOLD))
            iss_valid = sel_q & {NUM_UNITS{~hazard}};
        dispatch = |(iss_valid & bus.iss_ready_in);

        if (!bus.flush_in)
            dec_ready = (state_q == ST_EMPTY) || ((state_q == ST_HOLD) && dispatch);
        accept = bus.dec_valid_in & dec_ready;

        if (bus.flush_in) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = sel_onehot ? ST_HOLD : ST_TRAP;
                ST_HOLD:  if (dispatch) begin
                              if (accept) state_d = sel_onehot ? ST_HOLD : ST_TRAP;
                              else        state_d = ST_EMPTY;
                          end
                ST_TRAP:  state_d = ST_TRAP;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) state_q <= ST_EMPTY;
        else             state_q <= state_d;
    end

    // Instruction buffer, loaded on every accepted handshake
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sel_q <= '0;
            uop_q <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            rd_q  <= '0;
            we_q  <= 1'b0;
        end else if (accept) begin
            sel_q <= bus.dec_exec_unit_sel_in;
            uop_q <= bus.dec_exec_unit_uop_in;
            rs1_q <= bus.dec_rs1_in;
            rs2_q <= bus.dec_rs2_in;
            rd_q  <= bus.dec_rd_in;
            we_q  <= bus.dec_rd_write_enable_in;
        end
    end

    assign bus.dec_ready_out     = dec_ready;
    assign bus.iss_valid_out     = iss_valid;
    assign bus.iss_uop_out       = uop_q;
    assign bus.iss_rd_out        = rd_q;
    assign bus.iss_exception_out = (state_q == ST_TRAP);
    assign bus.iss_busy_out      = (state_q != ST_EMPTY) | any_pend;

endmodule : issue_scheduler

// File: tb/tb_issue_scheduler.sv
// Directed, table-driven bench for issue_scheduler.
module tb_issue_scheduler;
    import core101_iss_pkg::*;

    typedef struct {
        logic       flush;
        logic       dv;
        logic [3:0] sel;
        logic [3:0] uop;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       we;
        logic [3:0] rdy;
        logic       wbv;
        logic [4:0] wbrd;
        logic       e_drdy;
        logic [3:0] e_val;
        logic       e_exc;
        logic       e_busy;
        logic [3:0] e_uop;
        logic [4:0] e_rd;
    } vec_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    vec_t vecs[$];

    issue_scheduler_if #(.NUM_UNITS(4), .REG_ADDR_W(5), .UOP_W(4)) bus ();

    issue_scheduler dut (
        .clock_in   (clk),
        .reset_n_in (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int fl, input int dv, input int sel, input int uop,
                                input int rs1, input int rs2, input int rd, input int we,
                                input int rdy, input int wbv, input int wbrd,
                                input int edrdy, input int eval, input int eexc,
                                input int ebusy, input int euop, input int erd);
        vec_t v;
        v.flush  = 1'(fl);   v.dv     = 1'(dv);    v.sel   = 4'(sel);  v.uop    = 4'(uop);
        v.rs1    = 5'(rs1);  v.rs2    = 5'(rs2);   v.rd    = 5'(rd);   v.we     = 1'(we);
        v.rdy    = 4'(rdy);  v.wbv    = 1'(wbv);   v.wbrd  = 5'(wbrd);
        v.e_drdy = 1'(edrdy); v.e_val = 4'(eval);  v.e_exc = 1'(eexc); v.e_busy = 1'(ebusy);
        v.e_uop  = 4'(euop); v.e_rd   = 5'(erd);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.flush_in               = v.flush;
        bus.dec_valid_in           = v.dv;
        bus.dec_exec_unit_sel_in   = v.sel;
        bus.dec_exec_unit_uop_in   = v.uop;
        bus.dec_rs1_in             = v.rs1;
        bus.dec_rs2_in             = v.rs2;
        bus.dec_rd_in              = v.rd;
        bus.dec_rd_write_enable_in = v.we;
        bus.iss_ready_in           = v.rdy;
        bus.wb_valid_in            = v.wbv;
        bus.wb_rd_in               = v.wbrd;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic drdy, input logic [3:0] val,
                            input logic exc, input logic busy, input logic [3:0] uop,
                            input logic [4:0] rd);
        chk({tag, ".dec_ready"}, 32'(bus.dec_ready_out),     32'(drdy));
        chk({tag, ".iss_valid"}, 32'(bus.iss_valid_out),     32'(val));
        chk({tag, ".exception"}, 32'(bus.iss_exception_out), 32'(exc));
        chk({tag, ".busy"},      32'(bus.iss_busy_out),      32'(busy));
        chk({tag, ".uop"},       32'(bus.iss_uop_out),       32'(uop));
        chk({tag, ".rd"},        32'(bus.iss_rd_out),        32'(rd));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drive(mk(0,0,0,0,0,0,0,0,'b1111,0,0, 0,0,0,0,0,0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outs("reset", 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 5'd0);
        rst_n = 1'b1;

        //            fl dv sel           uop rs1 rs2 rd we rdy     wbv wbrd  drdy val     exc busy uop rd
        // Back-to-back issue, then retire rd 8 and rd 5
        vecs.push_back(mk(0,1,INT_EXEC_SEL,1, 1, 2, 5, 1,'b1111,0,0,   1,'b0000,0,0, 0, 0));
        vecs.push_back(mk(0,1,INT_EXEC_SEL,2, 6, 7, 8, 1,'b1111,0,0,   1,'b0001,0,1, 1, 5));
        vecs.push_back(mk(0,0,0,           0, 0, 0, 0, 0,'b1111,0,0,   1,'b0001,0,1, 2, 8));
        vecs.push_back(mk(0,0,0,           0, 0, 0, 0, 0,'b1111,1,8,   1,'b0000,0,1, 2, 8));
        vecs.push_back(mk(0,0,0,           0, 0, 0, 0, 0,'b1111,1,5,   1,'b0000,0,1, 2, 8));
        // RAW stall on rs1 = 5, released by writeback of 5
        vecs.push_back(mk(0,1,INT_EXEC_SEL,3, 0, 0, 5, 1,'b1111,0,0,   1,'b0000,0,0, 2, 8));
        vecs.push_back(mk(0,1,LSU_EXEC_SEL,4, 5, 3,10, 1,'b1111,0,0,   1,'b0001,0,1, 3, 5));
        vecs.push_back(mk(0,0,0,           0, 0, 0, 0, 0,'b1111,0,0,   0,'b0000,0,1, 4,10));
`ifdef ISS_WB_BYPASS_EN
        vecs.push_back(mk(0,0,0,           0, 0, 0, 0, 0,'b1111,1,5,   1,'b0100,0,1, 4,10));
        vecs.push_back(mk(0,0,0,           0, 0, 0, 0, 0,'b1111,0,0,   1,'b0000,0,1, 4,10));
`else
        vecs.push_back(mk(0,0,0,           0, 0, 0, 0, 0,'b1111,1,5,   0,'b0000,0,1, 4,10));
        vecs.push_back(mk(0,0,0,           0, 0, 0, 0, 0,'b1111,0,0,   1,'b0100,0,1, 4,10));
`endif
        vecs.push_back(mk(0,0,0,           0, 0, 0, 0, 0,'b1111,1,10,  1,'b0000,0,1, 4,10));
        // Backpressure on LSU for three cycles; decode offer is refused meanwhile
        vecs.push_back(mk(0,1,LSU_EXEC_SEL,5, 1, 2, 3, 0,'b1111,0,0,   1,'b0000,0,0, 4,10));
        vecs.push_back(mk(0,1,INT_EXEC_SEL,9, 0, 0,12, 1,'b1011,0,0,   0,'b0100,0,1, 5, 3));
        vecs.push_back(mk(0,1,INT_EXEC_SEL,9, 0, 0,12, 1,'b1011,0,0,   0,'b0100,0,1, 5, 3));
        vecs.push_back(mk(0,1,INT_EXEC_SEL,9, 0, 0,12, 1,'b1011,0,0,   0,'b0100,0,1, 5, 3));
        vecs.push_back(mk(0,0,0,           0, 0, 0, 0, 0,'b1111,0,0,   1,'b0100,0,1, 5, 3));
        // Invalid select 0000 -> trap, flush
        vecs.push_back(mk(0,1,'b0000,      6, 0, 0, 4, 1,'b1111,0,0,   1,'b0000,0,0, 5, 3));
        vecs.push_back(mk(0,1,INT_EXEC_SEL,1, 0, 0, 1, 1,'b1111,0,0,   0,'b0000,1,1, 6, 4));
        vecs.push_back(mk(1,0,0,           0, 0, 0, 0, 0,'b1111,0,0,   0,'b0000,1,1, 6, 4));
        // Invalid select 0110 -> trap, flush
        vecs.push_back(mk(0,1,'b0110,      7, 0, 0, 1, 1,'b1111,0,0,   1,'b0000,0,0, 6, 4));
        vecs.push_back(mk(1,0,0,           0, 0, 0, 0, 0,'b1111,0,0,   0,'b0000,1,1, 7, 1));
        // rd = x0 dispatch while an invalid one is accepted behind it
        vecs.push_back(mk(0,1,BRU_EXEC_SEL,8, 0, 0, 0, 1,'b1111,0,0,   1,'b0000,0,0, 7, 1));
        vecs.push_back(mk(0,1,'b1001,      9, 0, 0, 2, 1,'b1111,0,0,   1,'b0010,0,1, 8, 0));
        vecs.push_back(mk(1,0,0,           0, 0, 0, 0, 0,'b1111,0,0,   0,'b0000,1,1, 9, 2));
        // Dispatch rd 9 with same-cycle writeback of 9: bit stays set
        vecs.push_back(mk(0,1,VEC_EXEC_SEL,10,0, 0, 9, 1,'b1111,0,0,   1,'b0000,0,0, 9, 2));
        vecs.push_back(mk(0,0,0,           0, 0, 0, 0, 0,'b1111,1,9,   1,'b1000,0,1,10, 9));
        vecs.push_back(mk(0,1,INT_EXEC_SEL,11,9, 0, 0, 0,'b1111,0,0,   1,'b0000,0,1,10, 9));
        // Flush in HOLD leaves the scoreboard alone
        vecs.push_back(mk(1,0,0,           0, 0, 0, 0, 0,'b1111,0,0,   0,'b0000,0,1,11, 0));
        vecs.push_back(mk(0,0,0,           0, 0, 0, 0, 0,'b1111,1,9,   1,'b0000,0,1,11, 0));
        // Flush suppresses an otherwise ready dispatch and blocks decode
        vecs.push_back(mk(0,1,INT_EXEC_SEL,12,0, 0, 7, 1,'b1111,0,0,   1,'b0000,0,0,11, 0));
        vecs.push_back(mk(1,1,BRU_EXEC_SEL,13,0, 0, 6, 1,'b1111,0,0,   0,'b0000,0,1,12, 7));
        vecs.push_back(mk(0,0,0,           0, 0, 0, 0, 0,'b1111,0,0,   1,'b0000,0,0,12, 7));

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            @(negedge clk);
            chk_outs($sformatf("vec%0d", i), vecs[i].e_drdy, vecs[i].e_val, vecs[i].e_exc,
                     vecs[i].e_busy, vecs[i].e_uop, vecs[i].e_rd);
        end

        // Asynchronous reset while holding a stalled instruction with a pending register
        @(posedge clk); #1;
        drive(mk(0,1,INT_EXEC_SEL,14,0,0,11,1,'b1111,0,0, 0,0,0,0,0,0));
        @(posedge clk); #1;
        drive(mk(0,1,LSU_EXEC_SEL,15,0,0,12,1,'b1111,0,0, 0,0,0,0,0,0));
        @(posedge clk); #1;
        drive(mk(0,0,0,0,0,0,0,0,'b0000,0,0, 0,0,0,0,0,0));
        @(negedge clk);
        chk_outs("pre_rst", 1'b0, 4'b0100, 1'b0, 1'b1, 4'd15, 5'd12);
        #2 rst_n = 1'b0;
        #1;
        chk_outs("mid_rst", 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_outs("post_rst", 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 5'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_issue_scheduler
